sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/UART_pkg.sv | 16 +
 rtl/sipo_deser_bit_cnt.sv | 38 +++
 rtl/sipo_deser.sv | 139 +++++++++++++
 tb/tb_sipo_deser.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/UART_pkg.sv
// Shared types for the serial-in / parallel-out deserializer: FSM state
// encoding, default word width and the default-width word type.
package UART_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [DW_DEFAULT-1:0] word_t;

endpackage

// File: rtl/sipo_deser_bit_cnt.sv
// Received-bit counter for sipo_deser; tc flags that the bit being sampled
// is the last data bit of the word.
module sipo_bit_cnt #(
  parameter int DW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int              CW   = $clog2(DW);
  localparam logic [CW-1:0]   LAST = CW'(DW - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with optional parity bit, a one-deep
// output holding register, consumer acknowledge and sticky overrun flag.
module sipo_deser
  import UART_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          enb,
  input  logic          inp,
  input  logic          ack,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          busy,
  output logic          parity_err,
  output logic          overrun
);

  state_t        state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [DW-1:0] out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          overrun_q, overrun_d;
  logic          perr_samp_q, perr_samp_d;
  logic          cnt_clr, cnt_inc, cnt_tc;
  logic [DW-1:0] shifted;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {shreg_q[DW-2:0], inp};
    end else begin : g_lsb_first
      assign shifted = {inp, shreg_q[DW-1:1]};
    end
  endgenerate

  sipo_bit_cnt #(
    .DW (DW)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    perr_samp_d  = perr_samp_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    if (ack && out_valid_q) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
        end else if (enb) begin
          shreg_d = shifted;
          cnt_inc = 1'b1;
          if (cnt_tc) begin
            state_d = (PARITY_EN != 0) ? PARITY : DONE;
          end
        end
      end
      PARITY: begin
        if (start) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end else if (enb) begin
          perr_samp_d = ((^shreg_q) ^ inp) != (PARITY_ODD != 0);
          state_d     = DONE;
        end
      end
      DONE: begin
        // The new word always wins; only an unacknowledged old word is lost.
        out_d        = shreg_q;
        parity_err_d = (PARITY_EN != 0) ? perr_samp_q : 1'b0;
        if (out_valid_q && !ack) begin
          overrun_d = 1'b1;
        end
        out_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      perr_samp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      perr_samp_q  <= perr_samp_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: three instances (LSB-first, MSB-first, even parity)
// driven by a vector table, corner-case sequences and random frames.
module tb_sipo_deser;
  import UART_pkg::*;

  localparam int N  = 3;
  localparam int DW = DW_DEFAULT;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_s[N], start_s[N], enb_s[N], inp_s[N], ack_s[N];
  word_t out_s[N];
  logic  out_valid_s[N], busy_s[N], perr_s[N], ovr_s[N];

  sipo_deser #(.DW(DW), .MSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u_lsb (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .enb(enb_s[0]), .inp(inp_s[0]),
    .ack(ack_s[0]), .out(out_s[0]), .out_valid(out_valid_s[0]), .busy(busy_s[0]),
    .parity_err(perr_s[0]), .overrun(ovr_s[0]));

  sipo_deser #(.DW(DW), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_msb (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .enb(enb_s[1]), .inp(inp_s[1]),
    .ack(ack_s[1]), .out(out_s[1]), .out_valid(out_valid_s[1]), .busy(busy_s[1]),
    .parity_err(perr_s[1]), .overrun(ovr_s[1]));

  sipo_deser #(.DW(DW), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .enb(enb_s[2]), .inp(inp_s[2]),
    .ack(ack_s[2]), .out(out_s[2]), .out_valid(out_valid_s[2]), .busy(busy_s[2]),
    .parity_err(perr_s[2]), .overrun(ovr_s[2]));

  int checks   = 0;
  int failures = 0;

  // Reference model of the observable output register state.
  word_t m_out[N];
  logic  m_valid[N], m_perr[N], m_ovr[N];

  // Counts 0->1 transitions of out_valid, sampled on the falling edge.
  int   rises[N] = '{0, 0, 0};
  logic vprev[N] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (out_valid_s[i] && !vprev[i]) rises[i] <= rises[i] + 1;
      vprev[i] <= out_valid_s[i];
    end
  end

  typedef struct {
    int          d;
    logic [31:0] stream;    // bit i is the i-th bit put on the line
    logic        pbit;
    int          gap;
    word_t       exp_out;
    logic        exp_perr;
    logic        ack_after;
  } vec_t;

  vec_t vecs[7];

  function automatic bit is_msb(int d);
    return d == 1;
  endfunction

  function automatic bit has_par(int d);
    return d == 2;
  endfunction

  function automatic word_t exp_word(int d, logic [31:0] stream);
    word_t w = stream[DW-1:0];
    if (is_msb(d)) begin
      for (int i = 0; i < DW; i++) w[DW-1-i] = stream[i];
    end
    return w;
  endfunction

  function automatic logic exp_perr(int d, word_t w, logic pbit);
    int ones;
    if (!has_par(d)) return 1'b0;
    ones = $countones(w) + ((pbit == 1'b1) ? 1 : 0);
    return (ones % 2) == 1;
  endfunction

  task automatic chk1(string name, int d, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0b expected %0b", name, d, act, exp);
    end
  endtask

  task automatic chkw(string name, int d, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(int d);
    m_out[d]   = '0;
    m_valid[d] = 1'b0;
    m_perr[d]  = 1'b0;
    m_ovr[d]   = 1'b0;
  endtask

  task automatic check_outputs(string tag, int d);
    chkw({tag, "_out"},   d, out_s[d],       m_out[d]);
    chk1({tag, "_valid"}, d, out_valid_s[d], m_valid[d]);
    chk1({tag, "_perr"},  d, perr_s[d],      m_perr[d]);
    chk1({tag, "_ovr"},   d, ovr_s[d],       m_ovr[d]);
  endtask

  task automatic pulse_start(int d, logic with_enb);
    start_s[d] = 1'b1;
    enb_s[d]   = with_enb;
    inp_s[d]   = 1'b1;
    tick();
    start_s[d] = 1'b0;
    enb_s[d]   = 1'b0;
  endtask

  task automatic send_bit(int d, logic b, int gap);
    repeat (gap - 1) tick();
    enb_s[d] = 1'b1;
    inp_s[d] = b;
    tick();
    enb_s[d] = 1'b0;
    inp_s[d] = 1'($urandom);
  endtask

  task automatic send_frame(int d, logic [31:0] stream, logic pbit, int gap,
                            logic ack_done, int abort_at, logic start_in_done);
    word_t w;
    pulse_start(d, 1'b1);
    chk1("busy_after_start", d, busy_s[d], 1'b1);
    if (abort_at > 0) begin
      for (int i = 0; i < abort_at; i++) send_bit(d, 1'($urandom), gap);
      pulse_start(d, 1'b0);
    end
    for (int i = 0; i < DW; i++) send_bit(d, stream[i], gap);
    if (has_par(d)) send_bit(d, pbit, gap);
    chk1("busy_in_done", d, busy_s[d], 1'b1);
    chk1("valid_in_done", d, out_valid_s[d], m_valid[d]);
    ack_s[d]   = ack_done;
    start_s[d] = start_in_done;
    tick();
    ack_s[d]   = 1'b0;
    start_s[d] = 1'b0;
    w = exp_word(d, stream);
    if (!ack_done && m_valid[d]) m_ovr[d] = 1'b1;
    m_valid[d] = 1'b1;
    m_out[d]   = w;
    m_perr[d]  = exp_perr(d, w, pbit);
    check_outputs("frame", d);
    chk1("busy_after_done", d, busy_s[d], 1'b0);
    $display("tx dut%0d stream=0x%02h pbit=%0b gap=%0d abort=%0d ack=%0b -> out=0x%02h valid=%0b perr=%0b ovr=%0b",
             d, stream[DW-1:0], pbit, gap, abort_at, ack_done,
             out_s[d], out_valid_s[d], perr_s[d], ovr_s[d]);
  endtask

  task automatic do_ack(int d);
    ack_s[d] = 1'b1;
    tick();
    ack_s[d]   = 1'b0;
    m_valid[d] = 1'b0;
    check_outputs("ack", d);
    $display("tx dut%0d ack -> valid=%0b out=0x%02h", d, out_valid_s[d], out_s[d]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    vecs[0] = '{0, 32'hA5, 1'b0, 4, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{1, 32'hA5, 1'b0, 4, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{1, 32'h3C, 1'b0, 2, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{2, 32'h07, 1'b1, 3, 8'h07, 1'b0, 1'b1};
    vecs[4] = '{2, 32'h07, 1'b0, 1, 8'h07, 1'b1, 1'b1};
    vecs[5] = '{0, 32'h0F, 1'b0, 1, 8'h0F, 1'b0, 1'b0};
    vecs[6] = '{1, 32'h0F, 1'b0, 1, 8'hF0, 1'b0, 1'b0};

    for (int d = 0; d < N; d++) begin
      rst_s[d] = 1'b0; start_s[d] = 1'b0; enb_s[d] = 1'b0;
      inp_s[d] = 1'b0; ack_s[d] = 1'b0;
      model_reset(d);
    end
    tick();
    tick();
    for (int d = 0; d < N; d++) rst_s[d] = 1'b1;
    tick();
    for (int d = 0; d < N; d++) begin
      check_outputs("reset", d);
      chk1("reset_busy", d, busy_s[d], 1'b0);
    end

    // Table-driven scenarios with hand-derived expected words.
    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].d, vecs[k].stream, vecs[k].pbit, vecs[k].gap, 1'b0, 0, 1'b0);
      chkw("tbl_out", vecs[k].d, out_s[vecs[k].d], vecs[k].exp_out);
      chk1("tbl_perr", vecs[k].d, perr_s[vecs[k].d], vecs[k].exp_perr);
      if (vecs[k].ack_after) do_ack(vecs[k].d);
    end

    // Two frames without ack: overrun, second word kept; ack leaves overrun set.
    do_ack(0);
    send_frame(0, 32'h11, 1'b0, 2, 1'b0, 0, 1'b0);
    chk1("no_ovr_first", 0, ovr_s[0], 1'b0);
    send_frame(0, 32'h22, 1'b0, 2, 1'b0, 0, 1'b0);
    chkw("ovr_second_word", 0, out_s[0], 8'h22);
    chk1("ovr_set", 0, ovr_s[0], 1'b1);
    do_ack(0);
    chk1("ovr_sticky_valid", 0, out_valid_s[0], 1'b0);
    chk1("ovr_sticky", 0, ovr_s[0], 1'b1);

    // DONE coinciding with ack: new word wins, no overrun.
    chk1("pre_ackdone_valid", 1, out_valid_s[1], 1'b1);
    send_frame(1, 32'h81, 1'b0, 1, 1'b1, 0, 1'b0);
    chk1("ackdone_no_ovr", 1, ovr_s[1], 1'b0);
    chk1("ackdone_valid", 1, out_valid_s[1], 1'b1);

    // Abort after 4 bits then a full 0x5A: exactly one valid rise.
    for (int d = 0; d < N; d += 2) begin
      if (m_valid[d]) do_ack(d);
      r0 = rises[d];
      send_frame(d, 32'h5A, 1'b0, 2, 1'b0, 4, 1'b0);
      tick();
      chkw("abort_out", d, out_s[d], 8'h5A);
      chk1("abort_one_rise", d, (rises[d] - r0) == 1, 1'b1);
    end

    // start during DONE is ignored.
    send_frame(1, 32'hC3, 1'b0, 1, 1'b0, 0, 1'b1);

    // Reset mid-frame, with start/enb/ack asserted alongside it.
    for (int d = 0; d < N; d++) begin
      pulse_start(d, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(d, 1'b1, 1);
      rst_s[d] = 1'b0; start_s[d] = 1'b1; enb_s[d] = 1'b1; ack_s[d] = 1'b1;
      tick();
      rst_s[d] = 1'b1; start_s[d] = 1'b0; enb_s[d] = 1'b0; ack_s[d] = 1'b0;
      model_reset(d);
      check_outputs("midrst", d);
      chk1("midrst_busy", d, busy_s[d], 1'b0);
      $display("tx dut%0d mid-frame reset -> busy=%0b out=0x%02h", d, busy_s[d], out_s[d]);
      send_frame(d, 32'h5A, 1'b0, 1, 1'b0, 0, 1'b0);
    end

    // Random frames against the model.
    for (int it = 0; it < 60; it++) begin
      int   d;
      int   ab;
      d  = int'($urandom_range(0, N - 1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW - 1)) : 0;
      send_frame(d, $urandom, 1'($urandom), int'($urandom_range(1, 3)),
                 ($urandom_range(0, 3) == 0), ab, 1'($urandom));
      if ($urandom_range(0, 1) == 1) do_ack(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
